// File: rtl/mux_sync_transmitter_if.sv
// Bundle of the upstream word handshake and the receiver-side data/qualifier
// lines of mux_sync_transmitter. Signal names keep the transmitter's view:
// i_* are driven into the transmitter, o_* are driven by it.
interface mux_sync_transmitter_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data_bus;
  logic                  o_ready;
  logic                  i_ack;
  logic [DATA_WIDTH-1:0] o_data_bus;
  logic                  o_mux_select;
  logic                  o_busy;
  logic                  o_timeout;

  // Environment side: upstream producer plus destination-domain receiver.
  modport master (
    output i_valid,
    output i_data_bus,
    output i_ack,
    input  o_ready,
    input  o_data_bus,
    input  o_mux_select,
    input  o_busy,
    input  o_timeout
  );

  // Transmitter side.
  modport slave (
    input  i_valid,
    input  i_data_bus,
    input  i_ack,
    output o_ready,
    output o_data_bus,
    output o_mux_select,
    output o_busy,
    output o_timeout
  );
endinterface

// File: rtl/mux_sync_transmitter.sv
// Source side of a mux-recirculation clock-domain crossing. A word is
// registered onto o_data_bus, given one cycle to settle, then qualified with
// o_mux_select. The receiver answers with an asynchronous four-phase ack that
// is resynchronised here before it may steer the FSM.
//
// Optional feature: define MUX_SYNC_TX_TIMEOUT_EN to abort a transfer whose
// ack phase (rise or fall) takes TIMEOUT_CYCLES cycles; o_timeout then pulses
// for one cycle. Without the macro the block waits indefinitely and
// o_timeout is tied low.
module mux_sync_transmitter #(
  parameter int DATA_WIDTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mux_sync_transmitter_if.slave bus
);

  // Reject configurations the synchroniser and counter cannot honour.
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mux_sync_transmitter: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    sel_reg;
  logic [SYNC_STAGES-1:0]  ack_sync_reg;
  logic                    ack_s;

`ifdef MUX_SYNC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timeout_cnt_reg;
  logic             timeout_reg;
  logic             cnt_expired;

  // The counter reaches TIMEOUT_CYCLES on the edge where it would step past
  // TIMEOUT_CYCLES-1, so the abort lands exactly TIMEOUT_CYCLES cycles after
  // the phase was entered.
  assign cnt_expired = (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Resynchronise the receiver's asynchronous ack; only the last stage is used.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], bus.i_ack};
    end
  end

  assign ack_s = ack_sync_reg[SYNC_STAGES-1];

  // Four-phase handshake FSM with registered data, qualifier and timeout pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= IDLE;
      data_reg        <= '0;
      sel_reg         <= 1'b0;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
      timeout_reg     <= 1'b0;
      timeout_cnt_reg <= '0;
`endif
    end else begin
`ifdef MUX_SYNC_TX_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          // Accept only here; data_reg then holds until the next accept.
          if (bus.i_valid) begin
            data_reg  <= bus.i_data_bus;
            state_reg <= LAUNCH;
          end
        end

        LAUNCH: begin
          // Data has had a full cycle to settle before the qualifier rises.
          sel_reg   <= 1'b1;
          state_reg <= REQ;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
          timeout_cnt_reg <= '0;
`endif
        end

        REQ: begin
          if (ack_s) begin
            sel_reg   <= 1'b0;
            state_reg <= RELEASE;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
            timeout_cnt_reg <= '0;
          end else if (cnt_expired) begin
            timeout_reg <= 1'b1;
            sel_reg     <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
`endif
          end
        end

        RELEASE: begin
          // Wait for the receiver to drop ack before offering a new word.
          if (!ack_s) begin
            state_reg <= IDLE;
`ifdef MUX_SYNC_TX_TIMEOUT_EN
          end else if (cnt_expired) begin
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
`endif
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_data_bus   = data_reg;
  assign bus.o_mux_select = sel_reg;
  assign bus.o_ready      = (state_reg == IDLE);
  assign bus.o_busy       = (state_reg != IDLE);
`ifdef MUX_SYNC_TX_TIMEOUT_EN
  assign bus.o_timeout    = timeout_reg;
`else
  assign bus.o_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sync_transmitter.sv
// Self-checking bench for mux_sync_transmitter: a transfer-level model of the
// handshake is compared with the DUT every cycle, and directed scenarios pin
// literal values (captured words, transfer periods, pulse counts).
module tb_mux_sync_transmitter;
  localparam int DW = 4;
  localparam int SS = 2;
  localparam int TO = 8;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  mux_sync_transmitter_if #(.DATA_WIDTH(DW)) ifc();

  mux_sync_transmitter #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (SS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (ifc.slave)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- receiver model (stimulus) ----------------
  // mode 0: ack follows select immediately; 1: one cycle late; 2: forced level.
  int   rx_mode  = 0;
  logic rx_force = 1'b0;
  logic rx_d     = 1'b0;
  logic rx_prev  = 1'b0;

  always @(negedge i_clk) begin
    rx_prev = rx_d;
    rx_d    = ifc.o_mux_select;
    case (rx_mode)
      0:       ifc.i_ack = ifc.o_mux_select;
      1:       ifc.i_ack = rx_prev;
      default: ifc.i_ack = rx_force;
    endcase
  end

  // ---------------- transfer-level reference model ----------------
  // A transfer is: busy (word taken), then select shown, then ack seen,
  // then ack gone. The ack the block reacts to is i_ack as sampled SS edges ago.
  bit          m_busy, m_sel, m_seen, m_to;
  logic [DW-1:0] m_data;
  int          m_cnt;
  bit          m_hist [SS];
  bit          m_ack;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_busy = 0; m_sel = 0; m_seen = 0; m_to = 0; m_data = '0; m_cnt = 0;
      for (int i = 0; i < SS; i++) m_hist[i] = 0;
    end else begin
      m_ack = m_hist[SS-1];
      m_to  = 0;
      if (!m_busy) begin
        if (ifc.i_valid === 1'b1) begin
          m_busy = 1;
          m_data = ifc.i_data_bus;
        end
      end else if (!m_sel && !m_seen) begin
        m_sel = 1;
        m_cnt = 0;
      end else if (m_sel && m_ack) begin
        m_sel  = 0;
        m_seen = 1;
        m_cnt  = 0;
      end else if (!m_sel && !m_ack) begin
        m_busy = 0;
        m_seen = 0;
      end else begin
`ifdef MUX_SYNC_TX_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TO) begin
          m_to = 1; m_busy = 0; m_sel = 0; m_seen = 0;
        end
`endif
      end
      for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = (ifc.i_ack === 1'b1);
    end
  end

  // ---------------- compare + monitor process ----------------
  int            cyc = 0;
  int            sel_cycles = 0;
  int            to_pulses = 0;
  int            to_delay = -1;
  int            rise_cyc = 0;
  int            accept_cyc = 0;
  logic          prev_sel = 0, prev_busy = 0, prev_ready = 0;
  logic [DW-1:0] word_log [$];
  int            period_log [$];

  always @(posedge i_clk) begin
    #1;
    cyc++;
    if (i_rst_n) begin
      check("ready",  ifc.o_ready,      !m_busy);
      check("busy",   ifc.o_busy,       m_busy);
      check("select", ifc.o_mux_select, m_sel);
      check("data",   ifc.o_data_bus,   m_data);
      check("tmo",    ifc.o_timeout,    m_to);
    end
    if (ifc.o_mux_select && !prev_sel) begin
      word_log.push_back(ifc.o_data_bus);
      rise_cyc = cyc;
    end
    if (ifc.o_mux_select) sel_cycles++;
    if (ifc.o_timeout) begin
      to_pulses++;
      to_delay = cyc - rise_cyc;
    end
    if (ifc.o_busy && !prev_busy) accept_cyc = cyc;
    if (ifc.o_ready && !prev_ready && i_rst_n) period_log.push_back(cyc - accept_cyc);
    prev_sel   = ifc.o_mux_select;
    prev_busy  = ifc.o_busy;
    prev_ready = ifc.o_ready;
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (ifc.o_ready !== 1'b1 && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    check(name, ifc.o_ready, 1'b1);
  endtask

  task automatic send_pulse(input logic [DW-1:0] d);
    @(negedge i_clk);
    ifc.i_valid    = 1'b1;
    ifc.i_data_bus = d;
    @(negedge i_clk);
    check("accept_first_edge", ifc.o_busy, 1'b1);
    ifc.i_valid = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n0, p0, s0, t0;
    ifc.i_valid    = 1'b0;
    ifc.i_data_bus = '0;
    i_rst_n        = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_ready",  ifc.o_ready,      1'b1);
    check("rst_busy",   ifc.o_busy,       1'b0);
    check("rst_select", ifc.o_mux_select, 1'b0);
    check("rst_data",   ifc.o_data_bus,   4'h0);
    check("rst_tmo",    ifc.o_timeout,    1'b0);
    i_rst_n = 1'b1;

    // Single transfer, receiver one cycle late on both edges: 7 + 2 cycles.
    rx_mode = 1;
    n0 = word_log.size(); p0 = period_log.size();
    send_pulse(4'hA);
    wait_idle(40, "single_done");
    check("single_word",   (word_log.size() > n0) ? word_log[n0] : 4'h0, 4'hA);
    check("single_period", (period_log.size() > p0) ? period_log[p0] : 0, 9);
    check("single_hold",   ifc.o_data_bus, 4'hA);

    // Immediate receiver: minimum period 3 + 2*SYNC_STAGES = 7.
    rx_mode = 0;
    p0 = period_log.size();
    send_pulse(4'h6);
    wait_idle(40, "fast_done");
    check("fast_period", (period_log.size() > p0) ? period_log[p0] : 0, 7);

    // Back-to-back with valid held high: 3 then 5, in order.
    n0 = word_log.size();
    @(negedge i_clk);
    ifc.i_valid = 1'b1; ifc.i_data_bus = 4'h3;
    @(negedge i_clk);
    ifc.i_data_bus = 4'h5;
    check("b2b_hold3", ifc.o_data_bus, 4'h3);
    wait_idle(40, "b2b_first_done");
    @(negedge i_clk);
    check("b2b_second_accept", ifc.o_busy, 1'b1);
    ifc.i_valid = 1'b0;
    wait_idle(40, "b2b_second_done");
    check("b2b_count", word_log.size() - n0, 2);
    check("b2b_word0", (word_log.size() > n0)     ? word_log[n0]     : 4'h0, 4'h3);
    check("b2b_word1", (word_log.size() > n0 + 1) ? word_log[n0 + 1] : 4'h0, 4'h5);

    // Inputs ignored while busy.
    rx_mode = 2; rx_force = 1'b0;
    send_pulse(4'h9);
    repeat (3) @(negedge i_clk);
    ifc.i_valid = 1'b1; ifc.i_data_bus = 4'hF;
    repeat (2) @(negedge i_clk);
    check("ignore_data",   ifc.o_data_bus,   4'h9);
    check("ignore_select", ifc.o_mux_select, 1'b1);
    ifc.i_valid = 1'b0;
    rx_mode = 0;
    wait_idle(40, "ignore_done");
    check("ignore_final", ifc.o_data_bus, 4'h9);

    // Stuck ack from reset: one REQ cycle, then parked in RELEASE.
    rx_mode = 2; rx_force = 1'b1;
    @(negedge i_clk); i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk); i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    s0 = sel_cycles;
    send_pulse(4'h7);
    repeat (6) @(negedge i_clk);
    check("stuck_busy",     ifc.o_busy,       1'b1);
    check("stuck_select",   ifc.o_mux_select, 1'b0);
    check("stuck_sel_cyc",  sel_cycles - s0,  1);
    rx_force = 1'b0;
    wait_idle(40, "stuck_done");

    // Asynchronous reset in the middle of REQ.
    rx_mode = 2; rx_force = 1'b0;
    send_pulse(4'hC);
    @(negedge i_clk);
    check("mid_req_select", ifc.o_mux_select, 1'b1);
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_select", ifc.o_mux_select, 1'b0);
    check("async_rst_data",   ifc.o_data_bus,   4'h0);
    check("async_rst_ready",  ifc.o_ready,      1'b1);
    @(negedge i_clk); i_rst_n = 1'b1;

`ifdef MUX_SYNC_TX_TIMEOUT_EN
    // Receiver never answers: one pulse TO cycles after select rises.
    rx_mode = 2; rx_force = 1'b0;
    t0 = to_pulses;
    send_pulse(4'hB);
    wait_idle(40, "tmo_done");
    repeat (3) @(negedge i_clk);
    check("tmo_pulses", to_pulses - t0,   1);
    check("tmo_delay",  to_delay,         TO);
    check("tmo_select", ifc.o_mux_select, 1'b0);
    check("tmo_data",   ifc.o_data_bus,   4'hB);
`else
    t0 = to_pulses;
    repeat (3) @(negedge i_clk);
    check("no_tmo_pulses", to_pulses - t0, 0);
`endif

    repeat (3) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
